memory_access_unit: RTL and testbench

Pipeline memory stage. It consumes `executeMemoryPayload_` from the execute/memory register and produces the registered `memoryWritebackPayload_` for writeback. It drives a valid/ready data-memory request channel and accepts a response channel for loads. It also performs byte-lane alignment, load extraction and sign extension, misalignment detection, and stall generation for the hazard unit.

---
 rtl/memory_access_unit_pkg.sv | 63 ++++++
 rtl/memory_access_unit_load_aligner.sv | 27 ++
 rtl/memory_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_memory_access_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_unit_pkg.sv
// Shared types for the memory stage: payload bundles, control,
// memory FSM states and byte-lane helpers.
package memory_access_unit_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_MEM,
      WB_PC4
   } writebackType_;

   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_REQUEST,
      MEM_RESPONSE
   } memState_;

   typedef struct packed {
      logic          valid;
      logic          illegal;
      logic [31:0]   programCounter;
      logic [31:0]   programCounterPlus4;
      logic [31:0]   result;
      logic [31:0]   storeData;
      logic [4:0]    destinationRegister;
      logic          memoryReadEnable;
      logic          memoryWriteEnable;
      logic [1:0]    memoryWidth;
      logic          memorySigned;
      writebackType_ writebackType;
   } executeMemoryPayload_;

   typedef struct packed {
      logic        valid;
      logic        illegal;
      logic [31:0] programCounter;
      logic [4:0]  destinationRegister;
      logic [31:0] data;
      logic        writebackEnable;
   } memoryWritebackPayload_;

   typedef struct packed {
      logic stall;
      logic flush;
   } control;

   function automatic logic [3:0] byteEnable(
      input logic [1:0] width,
      input logic [1:0] offset
   );
      case (width)
         MEM_BYTE: byteEnable = 4'b0001 << offset;
         MEM_HALF: byteEnable = 4'b0011 << offset;
         MEM_WORD: byteEnable = 4'b1111;
         default:  byteEnable = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/memory_access_unit_load_aligner.sv
// Load extraction: shift the addressed lane down, then
// sign- or zero-extend to 32 bits.
module load_aligner
   import memory_access_unit_pkg::*;
(
   input  logic [31:0] dataReadData,
   input  logic [1:0]  offset,
   input  logic [1:0]  memoryWidth,
   input  logic        memorySigned,
   output logic [31:0] extendedData
);

   logic [31:0] w_shifted;

   assign w_shifted = dataReadData >> {offset, 3'b000};

   always_comb begin
      case (memoryWidth)
         MEM_BYTE: extendedData = {{24{memorySigned & w_shifted[7]}},
                                   w_shifted[7:0]};
         MEM_HALF: extendedData = {{16{memorySigned & w_shifted[15]}},
                                   w_shifted[15:0]};
         default:  extendedData = w_shifted;
      endcase
   end

endmodule

// File: rtl/memory_access_unit.sv
// Pipeline memory stage: data-bus handshake, lane alignment,
// load extraction, misalignment detection and stall generation.
module memory_access_unit
   import memory_access_unit_pkg::*;
#(
   parameter int addressWidth = 32
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  executeMemoryPayload_   executeMemoryPayload,
   input  control                 memoryControl,
   output logic                   stallRequest,
   output memoryWritebackPayload_ memoryWritebackPayload,
   output logic                   dataRequestValid,
   input  logic                   dataRequestReady,
   output logic [addressWidth-1:0] dataAddress,
   output logic                   dataWriteEnable,
   output logic [3:0]             dataByteEnable,
   output logic [31:0]            dataWriteData,
   input  logic                   dataResponseValid,
   input  logic [31:0]            dataReadData
);

   memState_               r_state;
   memState_               w_nextState;
   executeMemoryPayload_   r_inst;
   executeMemoryPayload_   w_cur;
   memoryWritebackPayload_ r_out;
   memoryWritebackPayload_ w_next;
   logic                   r_squash;
   logic                   r_holdValid;
   logic [31:0]            r_holdRegister;
   logic                   w_memOp;
   logic                   w_aligned;
   logic                   w_alignedOp;
   logic                   w_misaligned;
   logic                   w_update;
   logic                   w_done;
   logic                   w_request;
   logic                   w_retire;
   logic                   w_hold;
   logic                   w_pending;
   logic [31:0]            w_loadWord;
   logic [31:0]            w_loadData;

   // Once a transaction is in flight, work from the latched copy.
   assign w_cur = (r_state == MEM_IDLE) ? executeMemoryPayload : r_inst;

   assign w_memOp = w_cur.valid &
                    (w_cur.memoryReadEnable | w_cur.memoryWriteEnable);

   always_comb begin
      case (w_cur.memoryWidth)
         MEM_BYTE: w_aligned = 1'b1;
         MEM_HALF: w_aligned = ~w_cur.result[0];
         MEM_WORD: w_aligned = (w_cur.result[1:0] == 2'b00);
         default:  w_aligned = 1'b0;
      endcase
   end

   assign w_alignedOp  = w_memOp & w_aligned;
   assign w_misaligned = w_memOp & ~w_aligned;
   assign w_update     = ~memoryControl.stall | memoryControl.flush;
   assign w_done       = r_holdValid | dataResponseValid;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) r_state <= MEM_IDLE;
      else         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         MEM_IDLE:
            if (w_request && !w_retire)
               w_nextState = dataRequestReady ? MEM_RESPONSE
                                              : MEM_REQUEST;
         MEM_REQUEST:
            if (dataRequestReady)
               w_nextState = w_retire ? MEM_IDLE : MEM_RESPONSE;
         MEM_RESPONSE:
            if (w_retire) w_nextState = MEM_IDLE;
         default: w_nextState = MEM_IDLE;
      endcase
   end

   always_comb begin
      w_request = 1'b0;
      w_retire  = 1'b0;
      w_hold    = 1'b0;
      case (r_state)
         MEM_IDLE:
            if (memoryControl.flush || !w_alignedOp) begin
               w_retire = 1'b1;
            end else if (!memoryControl.stall) begin
               w_request = 1'b1;
               w_retire  = dataRequestReady & w_cur.memoryWriteEnable;
            end
         MEM_REQUEST: begin
            w_request = 1'b1;
            w_retire  = dataRequestReady & w_cur.memoryWriteEnable &
                        w_update;
            w_hold    = dataRequestReady & w_cur.memoryWriteEnable &
                        ~w_update;
         end
         MEM_RESPONSE: begin
            w_retire = w_done & w_update;
            w_hold   = w_done & ~w_update;
         end
         default: ;
      endcase
   end

   assign w_pending    = (r_state == MEM_IDLE) ? w_alignedOp : 1'b1;
   assign stallRequest = resetN & w_pending & ~w_retire;

   assign dataRequestValid = resetN & w_request;
   assign dataAddress      = dataRequestValid ?
                             {w_cur.result[31:2], 2'b00} : '0;
   assign dataWriteEnable  = dataRequestValid & w_cur.memoryWriteEnable;
   assign dataByteEnable   = dataRequestValid ?
      byteEnable(w_cur.memoryWidth, w_cur.result[1:0]) : 4'b0000;

   always_comb begin
      dataWriteData = 32'h0;
      if (dataRequestValid) begin
         case (w_cur.memoryWidth)
            MEM_BYTE: dataWriteData = {4{w_cur.storeData[7:0]}};
            MEM_HALF: dataWriteData = {2{w_cur.storeData[15:0]}};
            default:  dataWriteData = w_cur.storeData;
         endcase
      end
   end

   assign w_loadWord = r_holdValid ? r_holdRegister : dataReadData;

   load_aligner u_load_aligner (
      .dataReadData (w_loadWord),
      .offset       (w_cur.result[1:0]),
      .memoryWidth  (w_cur.memoryWidth),
      .memorySigned (w_cur.memorySigned),
      .extendedData (w_loadData)
   );

   always_comb begin
      w_next = '0;
      if (w_retire && !memoryControl.flush && !r_squash && w_cur.valid) begin
         w_next.valid               = 1'b1;
         w_next.illegal             = w_cur.illegal | w_misaligned;
         w_next.programCounter      = w_cur.programCounter;
         w_next.destinationRegister = w_cur.destinationRegister;
         case (w_cur.writebackType)
            WB_ALU:  w_next.data = w_cur.result;
            WB_PC4:  w_next.data = w_cur.programCounterPlus4;
            WB_MEM:  w_next.data = w_loadData;
            default: w_next.data = 32'h0;
         endcase
         w_next.writebackEnable = ~w_next.illegal &
                                  (w_cur.writebackType != WB_NONE) &
                                  (w_cur.destinationRegister != 5'd0);
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_out          <= '0;
         r_inst         <= '0;
         r_squash       <= 1'b0;
         r_holdValid    <= 1'b0;
         r_holdRegister <= 32'h0;
      end else begin
         if (w_update) r_out <= w_next;
         if (r_state == MEM_IDLE) r_inst <= executeMemoryPayload;
         if (r_state != MEM_IDLE && w_nextState == MEM_IDLE)
            r_squash <= 1'b0;
         else if (r_state != MEM_IDLE && memoryControl.flush)
            r_squash <= 1'b1;
         // A completion seen under stall parks here until it drops.
         if (w_retire) begin
            r_holdValid <= 1'b0;
         end else if (w_hold) begin
            r_holdValid <= 1'b1;
            if (dataResponseValid && !r_holdValid)
               r_holdRegister <= dataReadData;
         end
      end
   end

   assign memoryWritebackPayload = r_out;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit.
module tb_memory_access_unit;
   import memory_access_unit_pkg::*;

   logic                   clock = 1'b0;
   logic                   resetN;
   executeMemoryPayload_   ex;
   control                 ctl;
   logic                   stallRequest;
   memoryWritebackPayload_ wb;
   logic                   dataRequestValid;
   logic                   dataRequestReady;
   logic [31:0]            dataAddress;
   logic                   dataWriteEnable;
   logic [3:0]             dataByteEnable;
   logic [31:0]            dataWriteData;
   logic                   dataResponseValid;
   logic [31:0]            dataReadData;
   int                     checks = 0;
   int                     errors = 0;

   always #5 clock = ~clock;

   memory_access_unit #(.addressWidth(32)) dut (
      .clock                  (clock),
      .resetN                 (resetN),
      .executeMemoryPayload   (ex),
      .memoryControl          (ctl),
      .stallRequest           (stallRequest),
      .memoryWritebackPayload (wb),
      .dataRequestValid       (dataRequestValid),
      .dataRequestReady       (dataRequestReady),
      .dataAddress            (dataAddress),
      .dataWriteEnable        (dataWriteEnable),
      .dataByteEnable         (dataByteEnable),
      .dataWriteData          (dataWriteData),
      .dataResponseValid      (dataResponseValid),
      .dataReadData           (dataReadData)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_in();
      ex = '0;
      ex.writebackType = WB_NONE;
   endtask

   task automatic set_op(
      input logic          re,
      input logic          we,
      input logic [1:0]    w,
      input logic          sgn,
      input logic [31:0]   res,
      input logic [31:0]   sd,
      input logic [4:0]    rd,
      input writebackType_ wt
   );
      ex = '0;
      ex.valid               = 1'b1;
      ex.programCounter      = 32'h1000;
      ex.programCounterPlus4 = 32'h1004;
      ex.result              = res;
      ex.storeData           = sd;
      ex.destinationRegister = rd;
      ex.memoryReadEnable    = re;
      ex.memoryWriteEnable   = we;
      ex.memoryWidth         = w;
      ex.memorySigned        = sgn;
      ex.writebackType       = wt;
   endtask

   task automatic test_reset();
      clear_in();
      ctl = '0;
      dataRequestReady = 1'b0;
      dataResponseValid = 1'b0;
      dataReadData = 32'h0;
      resetN = 1'b1;
      #1 resetN = 1'b0;
      #2;
      checks++; if (wb !== '0) begin errors++;
         $display("FAIL rst_payload got %h want 0", wb); end
      checks++; if (dataRequestValid !== 1'b0) begin errors++;
         $display("FAIL rst_req got %b want 0", dataRequestValid); end
      checks++; if (stallRequest !== 1'b0) begin errors++;
         $display("FAIL rst_stall got %b want 0", stallRequest); end
      checks++; if ({dataWriteEnable, dataByteEnable} !== 5'b0) begin errors++;
         $display("FAIL rst_we_be got %b want 0", {dataWriteEnable, dataByteEnable}); end
      checks++; if ({dataAddress, dataWriteData} !== 64'h0) begin errors++;
         $display("FAIL rst_addr_wd got %h want 0", {dataAddress, dataWriteData}); end
      tick();
      tick();
      resetN = 1'b1;
   endtask

   task automatic test_alu();
      set_op(1'b0, 1'b0, MEM_BYTE, 1'b0, 32'h1234, 32'h0, 5'd5, WB_ALU);
      #1;
      checks++; if ({stallRequest, dataRequestValid} !== 2'b00) begin errors++;
         $display("FAIL alu_stall_req got %b want 00", {stallRequest, dataRequestValid}); end
      tick();
      checks++; if (wb.data !== 32'h1234) begin errors++;
         $display("FAIL alu_data got %h want 1234", wb.data); end
      checks++; if ({wb.valid, wb.writebackEnable, wb.destinationRegister} !== 7'b1_1_00101) begin errors++;
         $display("FAIL alu_flags got %b want 1100101", {wb.valid, wb.writebackEnable, wb.destinationRegister}); end
      set_op(1'b0, 1'b0, MEM_BYTE, 1'b0, 32'h77, 32'h0, 5'd0, WB_PC4);
      tick();
      checks++; if ({wb.data, wb.writebackEnable} !== {32'h1004, 1'b0}) begin errors++;
         $display("FAIL pc4_rd0 got %h/%b want 1004/0", wb.data, wb.writebackEnable); end
      clear_in();
   endtask

   task automatic test_load_byte();
      set_op(1'b1, 1'b0, MEM_BYTE, 1'b1, 32'h103, 32'h0, 5'd7, WB_MEM);
      dataRequestReady = 1'b1;
      #1;
      checks++; if ({dataRequestValid, dataWriteEnable, stallRequest} !== 3'b101) begin errors++;
         $display("FAIL lb_req got %b want 101", {dataRequestValid, dataWriteEnable, stallRequest}); end
      checks++; if ({dataAddress, dataByteEnable} !== {32'h100, 4'b1000}) begin errors++;
         $display("FAIL lb_addr_be got %h/%b want 100/1000", dataAddress, dataByteEnable); end
      tick();
      checks++; if (wb.valid !== 1'b0) begin errors++;
         $display("FAIL lb_early got %b want 0", wb.valid); end
      dataRequestReady = 1'b0;
      dataResponseValid = 1'b1;
      dataReadData = 32'h80FF_0011;
      #1;
      checks++; if ({stallRequest, dataRequestValid} !== 2'b00) begin errors++;
         $display("FAIL lb_resp_stall got %b want 00", {stallRequest, dataRequestValid}); end
      tick();
      dataResponseValid = 1'b0;
      checks++; if ({wb.data, wb.writebackEnable} !== {32'hFFFF_FF80, 1'b1}) begin errors++;
         $display("FAIL lb_data got %h/%b want ffffff80/1", wb.data, wb.writebackEnable); end
      clear_in();
   endtask

   task automatic test_load_half_unsigned();
      set_op(1'b1, 1'b0, MEM_HALF, 1'b0, 32'h2, 32'h0, 5'd9, WB_MEM);
      dataRequestReady = 1'b1;
      #1;
      checks++; if (dataByteEnable !== 4'b1100) begin errors++;
         $display("FAIL lhu_be got %b want 1100", dataByteEnable); end
      tick();
      dataRequestReady = 1'b0;
      dataResponseValid = 1'b1;
      dataReadData = 32'h8001_0000;
      tick();
      dataResponseValid = 1'b0;
      checks++; if (wb.data !== 32'h0000_8001) begin errors++;
         $display("FAIL lhu_data got %h want 00008001", wb.data); end
      clear_in();
   endtask

   task automatic test_store_backpressure();
      set_op(1'b0, 1'b1, MEM_HALF, 1'b0, 32'h202, 32'h0000_ABCD, 5'd0, WB_NONE);
      dataRequestReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dataRequestReady = 1'b1;
         #1;
         checks++; if ({dataRequestValid, dataWriteEnable, dataByteEnable} !== 6'b11_1100) begin errors++;
            $display("FAIL sh_req[%0d] got %b want 111100", i, {dataRequestValid, dataWriteEnable, dataByteEnable}); end
         checks++; if ({dataAddress, dataWriteData} !== {32'h200, 32'hABCD_ABCD}) begin errors++;
            $display("FAIL sh_data[%0d] got %h/%h want 200/abcdabcd", i, dataAddress, dataWriteData); end
         checks++; if (stallRequest !== (i < 3)) begin errors++;
            $display("FAIL sh_stall[%0d] got %b want %b", i, stallRequest, (i < 3)); end
         tick();
      end
      dataRequestReady = 1'b0;
      checks++; if ({wb.valid, wb.writebackEnable, wb.illegal} !== 3'b100) begin errors++;
         $display("FAIL sh_retire got %b want 100", {wb.valid, wb.writebackEnable, wb.illegal}); end
      clear_in();
   endtask

   task automatic test_store_byte_immediate();
      set_op(1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h501, 32'h0000_005A, 5'd0, WB_NONE);
      dataRequestReady = 1'b1;
      #1;
      checks++; if ({dataByteEnable, dataWriteData} !== {4'b0010, 32'h5A5A_5A5A}) begin errors++;
         $display("FAIL sb_lanes got %b/%h want 0010/5a5a5a5a", dataByteEnable, dataWriteData); end
      checks++; if (stallRequest !== 1'b0) begin errors++;
         $display("FAIL sb_stall got %b want 0", stallRequest); end
      tick();
      dataRequestReady = 1'b0;
      checks++; if (wb.valid !== 1'b1) begin errors++;
         $display("FAIL sb_retire got %b want 1", wb.valid); end
      clear_in();
   endtask

   task automatic test_misaligned();
      set_op(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h101, 32'h0, 5'd3, WB_MEM);
      dataRequestReady = 1'b1;
      #1;
      checks++; if ({dataRequestValid, stallRequest} !== 2'b00) begin errors++;
         $display("FAIL mis_req got %b want 00", {dataRequestValid, stallRequest}); end
      tick();
      dataRequestReady = 1'b0;
      checks++; if ({wb.valid, wb.illegal, wb.writebackEnable} !== 3'b110) begin errors++;
         $display("FAIL mis_flags got %b want 110", {wb.valid, wb.illegal, wb.writebackEnable}); end
      clear_in();
   endtask

   task automatic test_flush_idle();
      set_op(1'b0, 1'b0, MEM_BYTE, 1'b0, 32'h99, 32'h0, 5'd4, WB_ALU);
      ctl.flush = 1'b1;
      tick();
      ctl.flush = 1'b0;
      checks++; if ({wb.valid, wb.writebackEnable} !== 2'b00) begin errors++;
         $display("FAIL flush_idle got %b want 00", {wb.valid, wb.writebackEnable}); end
      clear_in();
   endtask

   task automatic test_flush_response();
      set_op(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h300, 32'h0, 5'd6, WB_MEM);
      dataRequestReady = 1'b1;
      tick();
      dataRequestReady = 1'b0;
      clear_in();
      ctl.flush = 1'b1;
      #1;
      checks++; if (stallRequest !== 1'b1) begin errors++;
         $display("FAIL fr_stall got %b want 1", stallRequest); end
      tick();
      ctl.flush = 1'b0;
      tick();
      dataResponseValid = 1'b1;
      dataReadData = 32'h1234_5678;
      #1;
      checks++; if (stallRequest !== 1'b0) begin errors++;
         $display("FAIL fr_resp_stall got %b want 0", stallRequest); end
      tick();
      dataResponseValid = 1'b0;
      checks++; if ({wb.valid, wb.writebackEnable, wb.data} !== 34'h0) begin errors++;
         $display("FAIL fr_bubble got %b/%b/%h want 0/0/0", wb.valid, wb.writebackEnable, wb.data); end
      set_op(1'b0, 1'b0, MEM_BYTE, 1'b0, 32'hA5, 32'h0, 5'd8, WB_ALU);
      #1;
      checks++; if (stallRequest !== 1'b0) begin errors++;
         $display("FAIL fr_idle_stall got %b want 0", stallRequest); end
      tick();
      checks++; if ({wb.valid, wb.data} !== {1'b1, 32'hA5}) begin errors++;
         $display("FAIL fr_idle_alu got %b/%h want 1/a5", wb.valid, wb.data); end
      clear_in();
   endtask

   task automatic test_stall_response();
      set_op(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h400, 32'h0, 5'd10, WB_MEM);
      dataRequestReady = 1'b1;
      tick();
      dataRequestReady = 1'b0;
      ctl.stall = 1'b1;
      dataResponseValid = 1'b1;
      dataReadData = 32'hCAFE_F00D;
      #1;
      checks++; if (stallRequest !== 1'b1) begin errors++;
         $display("FAIL st_stall0 got %b want 1", stallRequest); end
      tick();
      dataResponseValid = 1'b0;
      dataReadData = 32'h0;
      checks++; if (wb !== '0) begin errors++;
         $display("FAIL st_hold0 got %h want 0", wb); end
      #1;
      checks++; if (stallRequest !== 1'b1) begin errors++;
         $display("FAIL st_stall1 got %b want 1", stallRequest); end
      tick();
      checks++; if (wb !== '0) begin errors++;
         $display("FAIL st_hold1 got %h want 0", wb); end
      ctl.stall = 1'b0;
      #1;
      checks++; if (stallRequest !== 1'b0) begin errors++;
         $display("FAIL st_release got %b want 0", stallRequest); end
      tick();
      checks++; if ({wb.valid, wb.writebackEnable, wb.data} !== {2'b11, 32'hCAFE_F00D}) begin errors++;
         $display("FAIL st_data got %b/%b/%h want 1/1/cafef00d", wb.valid, wb.writebackEnable, wb.data); end
      clear_in();
   endtask

   task automatic test_reset_mid();
      set_op(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h500, 32'h0, 5'd11, WB_MEM);
      dataRequestReady = 1'b1;
      tick();
      dataRequestReady = 1'b0;
      resetN = 1'b0;
      #1;
      checks++; if ({dataRequestValid, stallRequest, dataAddress} !== 34'h0) begin errors++;
         $display("FAIL rm_outs got %b/%b/%h want 0/0/0", dataRequestValid, stallRequest, dataAddress); end
      checks++; if (wb !== '0) begin errors++;
         $display("FAIL rm_payload got %h want 0", wb); end
      tick();
      clear_in();
      resetN = 1'b1;
      dataResponseValid = 1'b1;
      dataReadData = 32'hDEAD_0000;
      #1;
      checks++; if ({dataRequestValid, stallRequest} !== 2'b00) begin errors++;
         $display("FAIL rm_idle got %b want 00", {dataRequestValid, stallRequest}); end
      tick();
      dataResponseValid = 1'b0;
      checks++; if (wb.valid !== 1'b0) begin errors++;
         $display("FAIL rm_ignored got %b want 0", wb.valid); end
      set_op(1'b0, 1'b0, MEM_BYTE, 1'b0, 32'h3C, 32'h0, 5'd12, WB_ALU);
      tick();
      checks++; if ({wb.valid, wb.data} !== {1'b1, 32'h3C}) begin errors++;
         $display("FAIL rm_alu got %b/%h want 1/3c", wb.valid, wb.data); end
      clear_in();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_byte();
      test_load_half_unsigned();
      test_store_backpressure();
      test_store_byte_immediate();
      test_misaligned();
      test_flush_idle();
      test_flush_response();
      test_stall_response();
      test_reset_mid();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
